conv_job_scheduler: RTL and testbench

//  Sequences the 3x3 convolve engine across a full IMG_W x IMG_H feature map for one command.

---
 rtl/conv_job_scheduler_pkg.sv | 31 +++
 rtl/conv_job_watchdog.sv | 37 +++
 rtl/conv_job_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_conv_job_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_job_scheduler_pkg.sv
// Shared types and defaults for the convolution job scheduler.
package conv_job_scheduler_pkg;

  localparam int unsigned IMG_W_DEF   = 28;
  localparam int unsigned IMG_H_DEF   = 28;
  localparam int unsigned K_DEF       = 3;
  localparam int unsigned ADDR_W_DEF  = 10;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned TIMEOUT_DEF = 64;

  localparam int unsigned STRIDE_W   = 3;
  localparam int unsigned STRIDE_MAX = (1 << STRIDE_W) - 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT,
    ST_WR1,
    ST_WR2,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } sched_state_e;

  // A done level held for several cycles must count as one completion.
  function automatic logic done_rise(input logic done, input logic done_q);
    return done & ~done_q;
  endfunction

endpackage

// File: rtl/conv_job_watchdog.sv
// Cycle watchdog for one engine job: start re-arms from zero, clear disarms.
module conv_job_watchdog
  import conv_job_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_clear,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;
  logic             armed;

  // Fires on the TIMEOUT-th waiting cycle after the start cycle.
  assign o_expired_c = armed && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (i_start) begin
      cnt   <= '0;
      armed <= 1'b1;
    end else if (i_clear) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (armed && !o_expired_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/conv_job_scheduler.sv
// Walks a 3x3 convolve engine over an IMG_W x IMG_H map, two outputs per job,
// and writes the returned sums row-major into the result memory.
module conv_job_scheduler
  import conv_job_scheduler_pkg::*;
#(
  parameter int unsigned IMG_W   = IMG_W_DEF,
  parameter int unsigned IMG_H   = IMG_H_DEF,
  parameter int unsigned K       = K_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [ADDR_W-1:0]   i_src_base,
  input  logic [ADDR_W-1:0]   i_kern_base,
  input  logic [ADDR_W-1:0]   i_dst_base,
  input  logic [STRIDE_W-1:0] i_stride,
  output logic                o_conv_start,
  output logic [ADDR_W-1:0]   o_conv_src_addr,
  output logic [ADDR_W-1:0]   o_conv_kern_addr,
  output logic [ADDR_W-1:0]   o_conv_dest1,
  output logic [ADDR_W-1:0]   o_conv_dest2,
  output logic [STRIDE_W-1:0] o_conv_stride,
  input  logic [DATA_W-1:0]   i_conv_sum1,
  input  logic [DATA_W-1:0]   i_conv_sum2,
  input  logic                i_conv_done,
  output logic                o_wr_en,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [DATA_W-1:0]   o_wr_data,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  localparam int unsigned DIM_MAX = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int unsigned POS_W   = $clog2(DIM_MAX + 2 * STRIDE_MAX + K + 1);

  sched_state_e state, state_d;

  logic [POS_W-1:0]  col, col_d;
  logic [POS_W-1:0]  row, row_d;
  logic [ADDR_W-1:0] row_base, row_base_d;
  logic [ADDR_W-1:0] row_step, row_step_d;
  logic [ADDR_W-1:0] dptr, dptr_d;
  logic [ADDR_W-1:0] src_base_q, dst_base_q;
  logic [DATA_W-1:0] sum2_q;
  logic              done_q;

  logic accept_c;
  logic done_rise_c;
  logic wd_expired_c;
  logic pair2_c;
  logic row_end_c;
  logic last_row_c;

  assign accept_c    = i_cmd_valid && o_cmd_ready;
  assign done_rise_c = done_rise(i_conv_done, done_q);

  // Window geometry for the job at (row, col).
  assign pair2_c    = (32'(col) + 32'(o_conv_stride) + K) <= IMG_W;
  assign row_end_c  = !pair2_c ||
                      ((32'(col) + 32'(o_conv_stride) + 32'(o_conv_stride) + K) > IMG_W);
  assign last_row_c = (32'(row) + 32'(o_conv_stride) + K) > IMG_H;

  conv_job_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (state == ST_ISSUE),
    .i_clear     (state != ST_WAIT),
    .o_expired_c (wd_expired_c)
  );

  // Next-state and datapath next values.
  always_comb begin
    state_d    = state;
    col_d      = col;
    row_d      = row;
    row_base_d = row_base;
    row_step_d = row_step;
    dptr_d     = dptr;

    case (state)
      ST_IDLE: begin
        if (accept_c) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        col_d      = '0;
        row_d      = '0;
        row_base_d = src_base_q;
        row_step_d = ADDR_W'(32'(o_conv_stride) * IMG_W);
        dptr_d     = dst_base_q;
        if (o_conv_stride == '0) state_d = ST_ERR;
        else if (!i_conv_done)   state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_rise_c) begin
          state_d = ST_WR1;
          dptr_d  = dptr + ADDR_W'(1);
        end else if (wd_expired_c) begin
          state_d = ST_ERR;
        end
      end
      ST_WR1: begin
        if (pair2_c) begin
          state_d = ST_WR2;
          dptr_d  = dptr + ADDR_W'(1);
        end else begin
          state_d = ST_NEXT;
        end
      end
      ST_WR2: begin
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        // Position only advances on the cycle the next job is actually issued.
        if (row_end_c && last_row_c) begin
          state_d = ST_DONE;
        end else if (!i_conv_done) begin
          state_d = ST_ISSUE;
          if (row_end_c) begin
            col_d      = '0;
            row_d      = POS_W'(32'(row) + 32'(o_conv_stride));
            row_base_d = row_base + row_step;
          end else begin
            col_d = POS_W'(32'(col) + 32'(o_conv_stride) + 32'(o_conv_stride));
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= ST_IDLE;
      col              <= '0;
      row              <= '0;
      row_base         <= '0;
      row_step         <= '0;
      dptr             <= '0;
      src_base_q       <= '0;
      dst_base_q       <= '0;
      sum2_q           <= '0;
      done_q           <= 1'b0;
      o_cmd_ready      <= 1'b1;
      o_conv_start     <= 1'b0;
      o_conv_src_addr  <= '0;
      o_conv_kern_addr <= '0;
      o_conv_dest1     <= '0;
      o_conv_dest2     <= '0;
      o_conv_stride    <= '0;
      o_wr_en          <= 1'b0;
      o_wr_addr        <= '0;
      o_wr_data        <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_err            <= 1'b0;
    end else begin
      state    <= state_d;
      col      <= col_d;
      row      <= row_d;
      row_base <= row_base_d;
      row_step <= row_step_d;
      dptr     <= dptr_d;
      done_q   <= i_conv_done;

      if (accept_c) begin
        src_base_q       <= i_src_base;
        dst_base_q       <= i_dst_base;
        o_conv_kern_addr <= i_kern_base;
        o_conv_stride    <= i_stride;
      end

      o_cmd_ready  <= (state_d == ST_IDLE);
      o_busy       <= (state_d != ST_IDLE);
      o_conv_start <= (state_d == ST_ISSUE);
      o_wr_en      <= (state_d == ST_WR1) || (state_d == ST_WR2);
      o_done       <= (state_d == ST_DONE) || (state_d == ST_ERR);
      o_err        <= (state_d == ST_ERR);

      if (state_d == ST_ISSUE) begin
        o_conv_src_addr <= row_base_d + ADDR_W'(col_d);
        o_conv_dest1    <= dptr_d;
        o_conv_dest2    <= dptr_d + ADDR_W'(1);
      end

      // Sums are captured on the done edge; sum2 is held for the second write.
      if (state_d == ST_WR1) begin
        o_wr_addr <= dptr;
        o_wr_data <= i_conv_sum1;
        sum2_q    <= i_conv_sum2;
      end
      if (state_d == ST_WR2) begin
        o_wr_addr <= dptr;
        o_wr_data <= sum2_q;
      end
    end
  end

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Randomized bench for conv_job_scheduler with a job-list reference model and engine model.
module tb_conv_job_scheduler;

  localparam int IMG_W   = 28;
  localparam int IMG_H   = 28;
  localparam int K       = 3;
  localparam int TIMEOUT = 64;

  typedef struct {
    logic [9:0] src;
    logic [9:0] dest;
    bit         pair;
  } job_t;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] src_base, kern_base, dst_base;
  logic [2:0] stride;
  logic       conv_start;
  logic [9:0] conv_src_addr, conv_kern_addr, conv_dest1, conv_dest2;
  logic [2:0] conv_stride;
  logic [7:0] conv_sum1, conv_sum2;
  logic       conv_done;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy, done, err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_start  = 0;
  int   n_wr     = 0;
  bit   eng_silent = 0;
  int   eng_lat    = 0;
  job_t exp_jobs[$];
  wr_t  exp_wr[$];

  always #5 clk = ~clk;

  conv_job_scheduler dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_cmd_valid      (cmd_valid),
    .o_cmd_ready      (cmd_ready),
    .i_src_base       (src_base),
    .i_kern_base      (kern_base),
    .i_dst_base       (dst_base),
    .i_stride         (stride),
    .o_conv_start     (conv_start),
    .o_conv_src_addr  (conv_src_addr),
    .o_conv_kern_addr (conv_kern_addr),
    .o_conv_dest1     (conv_dest1),
    .o_conv_dest2     (conv_dest2),
    .o_conv_stride    (conv_stride),
    .i_conv_sum1      (conv_sum1),
    .i_conv_sum2      (conv_sum2),
    .i_conv_done      (conv_done),
    .o_wr_en          (wr_en),
    .o_wr_addr        (wr_addr),
    .o_wr_data        (wr_data),
    .o_busy           (busy),
    .o_done           (done),
    .o_err            (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected job list: windows visited row-major, two per job when the second fits.
  task automatic build_model(input int s, input logic [9:0] src, input logic [9:0] dst);
    job_t       j;
    logic [9:0] d;
    d = dst;
    for (int r = 0; r + K <= IMG_H; r += s) begin
      for (int c = 0; c + K <= IMG_W; c += 2 * s) begin
        j.src  = 10'(int'(src) + r * IMG_W + c);
        j.dest = d;
        j.pair = (c + s + K <= IMG_W);
        d      = d + (j.pair ? 10'd2 : 10'd1);
        exp_jobs.push_back(j);
      end
    end
  endtask

  // Engine model: answers each start after a random latency with a random-length done.
  initial begin : engine
    job_t       j;
    wr_t        w;
    logic [9:0] d2;
    logic [7:0] s1, s2;
    int         lat, hold;
    bit         abort, have;
    conv_done = 1'b0;
    conv_sum1 = '0;
    conv_sum2 = '0;
    forever begin
      @(negedge clk);
      if (conv_start && !rst) begin
        check_eq("job_expected", 32'(exp_jobs.size() != 0), 1);
        have = (exp_jobs.size() != 0);
        if (have) begin
          j  = exp_jobs.pop_front();
          d2 = j.dest + 10'd1;
          check_eq("job_src", conv_src_addr, j.src);
          check_eq("job_dest1", conv_dest1, j.dest);
          check_eq("job_dest2", conv_dest2, d2);
        end
        s1   = 8'($urandom);
        s2   = 8'($urandom);
        lat  = (eng_lat != 0) ? eng_lat : int'($urandom_range(1, 4));
        hold = int'($urandom_range(1, 5));
        if (have && !eng_silent) begin
          w.addr = j.dest; w.data = s1; exp_wr.push_back(w);
          if (j.pair) begin
            w.addr = d2; w.data = s2; exp_wr.push_back(w);
          end
        end
        abort = 0;
        for (int i = 0; i < lat && !abort; i++) begin
          @(negedge clk);
          if (rst) abort = 1;
        end
        if (!abort && !eng_silent) begin
          conv_sum1 = s1;
          conv_sum2 = s2;
          conv_done = 1'b1;
          repeat (hold) @(negedge clk);
          conv_done = 1'b0;
        end
      end
    end
  end

  // Write monitor against the expected write stream.
  always @(negedge clk) begin
    wr_t w;
    if (conv_start) n_start++;
    if (wr_en) begin
      n_wr++;
      check_eq("wr_expected", 32'(exp_wr.size() != 0), 1);
      if (exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        check_eq("wr_addr", wr_addr, w.addr);
        check_eq("wr_data", wr_data, w.data);
      end
    end
  end

  task automatic send_cmd(input logic [2:0] s, input logic [9:0] src, input logic [9:0] kern,
                          input logic [9:0] dst);
    @(negedge clk);
    check_eq("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    stride    = s;
    src_base  = src;
    kern_base = kern;
    dst_base  = dst;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    stride    = 3'($urandom);
    src_base  = 10'($urandom);
    kern_base = 10'($urandom);
    dst_base  = 10'($urandom);
    check_eq("busy_after_accept", busy, 1);
    check_eq("ready_after_accept", cmd_ready, 0);
  endtask

  task automatic clear_model();
    exp_jobs.delete();
    exp_wr.delete();
    n_start = 0;
    n_wr    = 0;
  endtask

  task automatic run_cmd(input logic [2:0] s, input logic [9:0] src, input logic [9:0] kern,
                         input logic [9:0] dst);
    int cyc, exp_outs, exp_njobs, si;
    si = int'(s);
    clear_model();
    build_model(si, src, dst);
    exp_njobs = exp_jobs.size();
    exp_outs  = ((IMG_W - K) / si + 1) * ((IMG_H - K) / si + 1);
    send_cmd(s, src, kern, dst);
    cyc = 0;
    while (!done && cyc < 30000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("done_seen", done, 1);
    check_eq("err_clear", err, 0);
    check_eq("kern_latched", conv_kern_addr, kern);
    check_eq("stride_latched", conv_stride, s);
    @(negedge clk);
    check_eq("done_one_cycle", done, 0);
    check_eq("ready_after_done", cmd_ready, 1);
    check_eq("start_count", n_start, exp_njobs);
    check_eq("write_count", n_wr, exp_outs);
    check_eq("jobs_left", exp_jobs.size(), 0);
    check_eq("writes_left", exp_wr.size(), 0);
  endtask

  initial begin : main
    int         cyc, n;
    logic [9:0] a, b, c;
    rst = 1'b1;
    cmd_valid = 1'b0;
    stride = '0; src_base = '0; kern_base = '0; dst_base = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_start", conv_start, 0);
    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_done", done, 0);
    rst = 1'b0;

    // Full map at stride 1 and 2, then strides 3..7 with wrapping bases.
    run_cmd(3'd1, 10'd0, 10'd900, 10'd0);
    check_eq("s1_jobs_338", n_start, 338);
    check_eq("s1_writes_676", n_wr, 676);
    run_cmd(3'd2, 10'($urandom), 10'($urandom), 10'($urandom));
    check_eq("s2_writes_169", n_wr, 169);
    for (int s = 3; s <= 7; s++) run_cmd(3'(s), 10'($urandom), 10'($urandom), 10'($urandom));

    // Illegal stride.
    clear_model();
    send_cmd(3'd0, 10'd5, 10'd6, 10'd7);
    check_eq("s0_no_done_yet", done, 0);
    @(negedge clk);
    check_eq("s0_done", done, 1);
    check_eq("s0_err", err, 1);
    repeat (3) @(negedge clk);
    check_eq("s0_ready", cmd_ready, 1);
    check_eq("s0_no_start", n_start, 0);
    check_eq("s0_no_write", n_wr, 0);

    // Silent engine: watchdog ends the command.
    clear_model();
    build_model(1, 10'd100, 10'd200);
    eng_silent = 1;
    send_cmd(3'd1, 10'd100, 10'd7, 10'd200);
    cyc = 0;
    while (!conv_start && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("to_start_seen", conv_start, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err && n < 200);
    check_eq("to_latency", n, TIMEOUT + 1);
    check_eq("to_done", done, 1);
    check_eq("to_one_job", n_start, 1);
    check_eq("to_no_write", n_wr, 0);
    @(negedge clk);
    check_eq("to_ready", cmd_ready, 1);
    eng_silent = 0;
    repeat (6) @(negedge clk);
    run_cmd(3'd5, 10'($urandom), 10'($urandom), 10'($urandom));

    // Reset while job 5 is in flight.
    a = 10'd333; b = 10'd444; c = 10'd555;
    clear_model();
    build_model(1, a, c);
    eng_lat = 8;
    send_cmd(3'd1, a, b, c);
    cyc = 0;
    while (n_start < 5 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rst_job5_reached", n_start, 5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_ready", cmd_ready, 1);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_start", conv_start, 0);
    check_eq("mid_rst_wr_en", wr_en, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_err", err, 0);
    check_eq("mid_rst_src", conv_src_addr, 0);
    check_eq("mid_rst_dest1", conv_dest1, 0);
    check_eq("mid_rst_kern", conv_kern_addr, 0);
    check_eq("mid_rst_stride", conv_stride, 0);
    @(negedge clk);
    rst = 1'b0;
    eng_lat = 0;
    run_cmd(3'd4, 10'($urandom), 10'($urandom), 10'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
